// File: rtl/multi_cycle_control_fsm.sv
// Multi-cycle RISC-V sequencer: steps each instruction through IF/ID/EX/MEM/WB with a req/ready memory handshake.
// Define PERF_COUNTER_EN to add the cycle_count / instret_count outputs.
module multi_cycle_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        ecall_halt,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        alu_force_add,
  output logic        pc_write,
  output logic [1:0]  pc_source,
  output logic        is_halted,
  output logic        bus_error,
`ifdef PERF_COUNTER_EN
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count,
`endif
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IF      = 3'd0,
    S_ID      = 3'd1,
    S_EX      = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5,
    S_ERR     = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  localparam int unsigned      CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_waiting;
  logic             w_timeout;

  // A wait cycle that would make the count reach TIMEOUT_CYCLES is the last one tolerated.
  assign w_waiting = ((r_state == S_IF) || (r_state == S_MEM)) && !mem_ready;
  assign w_timeout = w_waiting && (r_wait_cnt == WAIT_LIMIT);
  assign state     = r_state;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IF;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_waiting && (w_next_state == r_state)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  // NOTE: every output and the next state get a default first, so no path through the case infers a latch.
  always_comb begin
    w_next_state  = r_state;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_force_add = 1'b0;
    pc_write      = 1'b0;
    pc_source     = 2'd0;
    is_halted     = 1'b0;
    bus_error     = 1'b0;

    case (r_state)
      S_IF: begin
        mem_req       = 1'b1;
        alu_src_b     = 2'd2;
        alu_force_add = 1'b1;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_next_state = S_ID;
        end else if (w_timeout) begin
          w_next_state = S_ERR;
        end
      end

      S_ID: begin
        alu_src_b     = 2'd1;
        alu_force_add = 1'b1;
        case (opcode)
          OP_SYSTEM:  w_next_state = ecall_halt ? S_HALT : S_IF;
          OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
          OP_BRANCH, OP_JAL, OP_JALR: w_next_state = S_EX;
          default:    w_next_state = S_IF;
        endcase
      end

      S_EX: begin
        w_next_state = S_IF;
        case (opcode)
          OP_ARITH: begin
            alu_src_a    = 1'b1;
            w_next_state = S_WB;
          end
          OP_ARITH_IMM: begin
            alu_src_a    = 1'b1;
            alu_src_b    = 2'd1;
            w_next_state = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'd1;
            alu_force_add = 1'b1;
            w_next_state  = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1;
            if (branch_taken) begin
              pc_write  = 1'b1;
              pc_source = 2'd1;
            end
          end
          OP_JAL: begin
            pc_write  = 1'b1;
            pc_source = 2'd1;
            reg_write = 1'b1;
            wb_sel    = 2'd2;
          end
          OP_JALR: begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'd1;
            alu_force_add = 1'b1;
            pc_write      = 1'b1;
            pc_source     = 2'd2;
            reg_write     = 1'b1;
            wb_sel        = 2'd2;
          end
          default: w_next_state = S_IF;
        endcase
      end

      S_MEM: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        mem_write = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_LOAD) begin
            mdr_write    = 1'b1;
            w_next_state = S_WB;
          end else begin
            w_next_state = S_IF;
          end
        end else if (w_timeout) begin
          w_next_state = S_ERR;
        end
      end

      S_WB: begin
        reg_write    = 1'b1;
        wb_sel       = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
        w_next_state = S_IF;
      end

      S_HALT: is_halted = 1'b1;

      S_ERR: begin
        is_halted = 1'b1;
        bus_error = 1'b1;
      end

      default: w_next_state = S_ERR;
    endcase
  end

`ifdef PERF_COUNTER_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instret_count;
  logic        w_retire;

  // An instruction retires whenever the sequencer returns to IF from a later stage.
  assign w_retire = (w_next_state == S_IF) &&
                    ((r_state == S_ID) || (r_state == S_EX) ||
                     (r_state == S_MEM) || (r_state == S_WB));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cycle_count   <= '0;
      r_instret_count <= '0;
    end else begin
      if ((r_state != S_HALT) && (r_state != S_ERR)) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if (w_retire) begin
        r_instret_count <= r_instret_count + 32'd1;
      end
    end
  end

  assign cycle_count   = r_cycle_count;
  assign instret_count = r_instret_count;
`endif

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Directed bench for multi_cycle_control_fsm: per-cycle opcode/ready/reset vectors against hand-built control words.
`timescale 1ns/1ps
module tb_multi_cycle_control_fsm;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  typedef struct packed {
    logic [2:0] st;
    logic       req, wr, iod, irw, mdrw, rw;
    logic [1:0] wbs;
    logic       sa;
    logic [1:0] sb;
    logic       fa, pcw;
    logic [1:0] pcs;
    logic       h, e;
  } ctl_t;

  typedef struct {
    logic [6:0] op;
    logic       rst, rdy, bt, eh;
    ctl_t       exp;
  } vec_t;

  localparam ctl_t V_IF_WAIT = '{st:3'd0, req:1'b1, sb:2'd2, fa:1'b1, default:'0};
  localparam ctl_t V_IF_GO   = '{st:3'd0, req:1'b1, irw:1'b1, sb:2'd2, fa:1'b1, pcw:1'b1, default:'0};
  localparam ctl_t V_ID      = '{st:3'd1, sb:2'd1, fa:1'b1, default:'0};
  localparam ctl_t V_EX_R    = '{st:3'd2, sa:1'b1, default:'0};
  localparam ctl_t V_EX_I    = '{st:3'd2, sa:1'b1, sb:2'd1, default:'0};
  localparam ctl_t V_EX_LS   = '{st:3'd2, sa:1'b1, sb:2'd1, fa:1'b1, default:'0};
  localparam ctl_t V_EX_BT   = '{st:3'd2, sa:1'b1, pcw:1'b1, pcs:2'd1, default:'0};
  localparam ctl_t V_EX_JAL  = '{st:3'd2, rw:1'b1, wbs:2'd2, pcw:1'b1, pcs:2'd1, default:'0};
  localparam ctl_t V_EX_JALR = '{st:3'd2, rw:1'b1, wbs:2'd2, sa:1'b1, sb:2'd1, fa:1'b1,
                                 pcw:1'b1, pcs:2'd2, default:'0};
  localparam ctl_t V_MEM_RD  = '{st:3'd3, req:1'b1, iod:1'b1, default:'0};
  localparam ctl_t V_MEM_LD  = '{st:3'd3, req:1'b1, iod:1'b1, mdrw:1'b1, default:'0};
  localparam ctl_t V_MEM_ST  = '{st:3'd3, req:1'b1, wr:1'b1, iod:1'b1, default:'0};
  localparam ctl_t V_WB_R    = '{st:3'd4, rw:1'b1, default:'0};
  localparam ctl_t V_WB_LD   = '{st:3'd4, rw:1'b1, wbs:2'd1, default:'0};
  localparam ctl_t V_HALT    = '{st:3'd5, h:1'b1, default:'0};
  localparam ctl_t V_ERR     = '{st:3'd6, h:1'b1, e:1'b1, default:'0};

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic       branch_taken, ecall_halt, mem_ready;
  logic       mem_req, mem_write, i_or_d, ir_write, mdr_write, reg_write;
  logic [1:0] wb_sel, alu_src_b, pc_source;
  logic       alu_src_a, alu_force_add, pc_write, is_halted, bus_error;
  logic [2:0] state;
`ifdef PERF_COUNTER_EN
  logic [31:0] cycle_count, instret_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ctl_t obs;
  assign obs = {state, mem_req, mem_write, i_or_d, ir_write, mdr_write, reg_write, wb_sel,
                alu_src_a, alu_src_b, alu_force_add, pc_write, pc_source, is_halted, bus_error};

  always #5 clk = ~clk;

  multi_cycle_control_fsm #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .branch_taken  (branch_taken),
    .ecall_halt    (ecall_halt),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .mdr_write     (mdr_write),
    .reg_write     (reg_write),
    .wb_sel        (wb_sel),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_force_add (alu_force_add),
    .pc_write      (pc_write),
    .pc_source     (pc_source),
    .is_halted     (is_halted),
    .bus_error     (bus_error),
`ifdef PERF_COUNTER_EN
    .cycle_count   (cycle_count),
    .instret_count (instret_count),
`endif
    .state         (state)
  );

  task automatic do_reset();
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; opcode = '0; mem_ready = 1'b0; branch_taken = 1'b0; ecall_halt = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    n_tests++;
    if (obs !== V_IF_WAIT) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", obs, V_IF_WAIT);
    end
    mem_ready = 1'b1;
    #1;
    n_tests++;
    if (obs !== V_IF_GO) begin
      n_fail++;
      $display("FAIL reset_fetch: got %h expected %h", obs, V_IF_GO);
    end
  endtask

  task automatic test_arith();
    vec_t v[$];
    do_reset();
    v.push_back('{OP_R, 1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
    v.push_back('{OP_R, 1'b0, 1'b0, 1'b0, 1'b0, V_ID});
    v.push_back('{OP_R, 1'b0, 1'b0, 1'b0, 1'b0, V_EX_R});
    v.push_back('{OP_R, 1'b0, 1'b0, 1'b0, 1'b0, V_WB_R});
    v.push_back('{OP_I, 1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
    v.push_back('{OP_I, 1'b0, 1'b1, 1'b0, 1'b0, V_ID});
    v.push_back('{OP_I, 1'b0, 1'b1, 1'b0, 1'b0, V_EX_I});
    v.push_back('{OP_I, 1'b0, 1'b1, 1'b0, 1'b0, V_WB_R});
    v.push_back('{OP_I, 1'b0, 1'b0, 1'b0, 1'b0, V_IF_WAIT});
    foreach (v[i]) begin
      opcode = v[i].op; reset_n = !v[i].rst; mem_ready = v[i].rdy;
      branch_taken = v[i].bt; ecall_halt = v[i].eh;
      #1;
      n_tests++;
      if (obs !== v[i].exp) begin
        n_fail++;
        $display("FAIL arith[%0d]: got %h expected %h", i, obs, v[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_store();
    vec_t v[$];
    do_reset();
    for (int k = 0; k < 3; k++) v.push_back('{OP_LD, 1'b0, 1'b0, 1'b0, 1'b0, V_IF_WAIT});
    v.push_back('{OP_LD, 1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
    v.push_back('{OP_LD, 1'b0, 1'b0, 1'b0, 1'b0, V_ID});
    v.push_back('{OP_LD, 1'b0, 1'b0, 1'b0, 1'b0, V_EX_LS});
    for (int k = 0; k < 3; k++) v.push_back('{OP_LD, 1'b0, 1'b0, 1'b0, 1'b0, V_MEM_RD});
    v.push_back('{OP_LD, 1'b0, 1'b1, 1'b0, 1'b0, V_MEM_LD});
    v.push_back('{OP_LD, 1'b0, 1'b0, 1'b0, 1'b0, V_WB_LD});
    v.push_back('{OP_ST, 1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
    v.push_back('{OP_ST, 1'b0, 1'b0, 1'b0, 1'b0, V_ID});
    v.push_back('{OP_ST, 1'b0, 1'b0, 1'b0, 1'b0, V_EX_LS});
    v.push_back('{OP_ST, 1'b0, 1'b1, 1'b0, 1'b0, V_MEM_ST});
    v.push_back('{OP_LD, 1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
    v.push_back('{OP_LD, 1'b0, 1'b0, 1'b0, 1'b0, V_ID});
    v.push_back('{OP_LD, 1'b0, 1'b0, 1'b0, 1'b0, V_EX_LS});
    v.push_back('{OP_LD, 1'b0, 1'b0, 1'b0, 1'b0, V_MEM_RD});
    v.push_back('{OP_LD, 1'b1, 1'b1, 1'b0, 1'b0, V_MEM_LD});
    v.push_back('{OP_LD, 1'b0, 1'b0, 1'b0, 1'b0, V_IF_WAIT});
    foreach (v[i]) begin
      opcode = v[i].op; reset_n = !v[i].rst; mem_ready = v[i].rdy;
      branch_taken = v[i].bt; ecall_halt = v[i].eh;
      #1;
      n_tests++;
      if (obs !== v[i].exp) begin
        n_fail++;
        $display("FAIL load_store[%0d]: got %h expected %h", i, obs, v[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    vec_t v[$];
    do_reset();
    v.push_back('{OP_BR,   1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
    v.push_back('{OP_BR,   1'b0, 1'b0, 1'b1, 1'b0, V_ID});
    v.push_back('{OP_BR,   1'b0, 1'b0, 1'b1, 1'b0, V_EX_BT});
    v.push_back('{OP_BR,   1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
    v.push_back('{OP_BR,   1'b0, 1'b0, 1'b0, 1'b0, V_ID});
    v.push_back('{OP_BR,   1'b0, 1'b0, 1'b0, 1'b0, V_EX_R});
    v.push_back('{OP_JAL,  1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
    v.push_back('{OP_JAL,  1'b0, 1'b0, 1'b0, 1'b0, V_ID});
    v.push_back('{OP_JAL,  1'b0, 1'b0, 1'b0, 1'b0, V_EX_JAL});
    v.push_back('{OP_JALR, 1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
    v.push_back('{OP_JALR, 1'b0, 1'b0, 1'b0, 1'b0, V_ID});
    v.push_back('{OP_JALR, 1'b0, 1'b0, 1'b0, 1'b0, V_EX_JALR});
    v.push_back('{OP_JALR, 1'b0, 1'b0, 1'b0, 1'b0, V_IF_WAIT});
    foreach (v[i]) begin
      opcode = v[i].op; reset_n = !v[i].rst; mem_ready = v[i].rdy;
      branch_taken = v[i].bt; ecall_halt = v[i].eh;
      #1;
      n_tests++;
      if (obs !== v[i].exp) begin
        n_fail++;
        $display("FAIL branch_jump[%0d]: got %h expected %h", i, obs, v[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ecall_halt();
    vec_t v[$];
    do_reset();
    v.push_back('{OP_BAD, 1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
    v.push_back('{OP_BAD, 1'b0, 1'b0, 1'b0, 1'b1, V_ID});
    v.push_back('{OP_SYS, 1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
    v.push_back('{OP_SYS, 1'b0, 1'b0, 1'b0, 1'b0, V_ID});
    v.push_back('{OP_SYS, 1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
    v.push_back('{OP_SYS, 1'b0, 1'b0, 1'b0, 1'b1, V_ID});
    for (int k = 0; k < 20; k++) v.push_back('{OP_SYS, 1'b0, 1'b1, 1'b1, 1'b0, V_HALT});
    foreach (v[i]) begin
      opcode = v[i].op; reset_n = !v[i].rst; mem_ready = v[i].rdy;
      branch_taken = v[i].bt; ecall_halt = v[i].eh;
      #1;
      n_tests++;
      if (obs !== v[i].exp) begin
        n_fail++;
        $display("FAIL ecall_halt[%0d]: got %h expected %h", i, obs, v[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    vec_t v[$];
    do_reset();
    for (int k = 0; k < 3; k++) v.push_back('{OP_R, 1'b0, 1'b0, 1'b0, 1'b0, V_IF_WAIT});
    v.push_back('{OP_R, 1'b1, 1'b0, 1'b0, 1'b0, V_IF_WAIT});
    for (int k = 0; k < 4; k++) v.push_back('{OP_R, 1'b0, 1'b0, 1'b0, 1'b0, V_IF_WAIT});
    v.push_back('{OP_R,  1'b0, 1'b0, 1'b0, 1'b0, V_ERR});
    v.push_back('{OP_R,  1'b0, 1'b1, 1'b0, 1'b0, V_ERR});
    v.push_back('{OP_LD, 1'b1, 1'b1, 1'b0, 1'b0, V_ERR});
    v.push_back('{OP_LD, 1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
    v.push_back('{OP_LD, 1'b0, 1'b0, 1'b0, 1'b0, V_ID});
    v.push_back('{OP_LD, 1'b0, 1'b0, 1'b0, 1'b0, V_EX_LS});
    for (int k = 0; k < 4; k++) v.push_back('{OP_LD, 1'b0, 1'b0, 1'b0, 1'b0, V_MEM_RD});
    v.push_back('{OP_LD, 1'b0, 1'b1, 1'b0, 1'b0, V_ERR});
    foreach (v[i]) begin
      opcode = v[i].op; reset_n = !v[i].rst; mem_ready = v[i].rdy;
      branch_taken = v[i].bt; ecall_halt = v[i].eh;
      #1;
      n_tests++;
      if (obs !== v[i].exp) begin
        n_fail++;
        $display("FAIL timeout[%0d]: got %h expected %h", i, obs, v[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef PERF_COUNTER_EN
  task automatic test_perf();
    vec_t v[$];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      v.push_back('{OP_R, 1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
      v.push_back('{OP_R, 1'b0, 1'b0, 1'b0, 1'b0, V_ID});
      v.push_back('{OP_R, 1'b0, 1'b0, 1'b0, 1'b0, V_EX_R});
      v.push_back('{OP_R, 1'b0, 1'b0, 1'b0, 1'b0, V_WB_R});
    end
    v.push_back('{OP_SYS, 1'b0, 1'b1, 1'b0, 1'b0, V_IF_GO});
    v.push_back('{OP_SYS, 1'b0, 1'b0, 1'b0, 1'b1, V_ID});
    for (int k = 0; k < 5; k++) v.push_back('{OP_SYS, 1'b0, 1'b0, 1'b0, 1'b0, V_HALT});
    foreach (v[i]) begin
      opcode = v[i].op; reset_n = !v[i].rst; mem_ready = v[i].rdy;
      branch_taken = v[i].bt; ecall_halt = v[i].eh;
      #1;
      n_tests++;
      if (obs !== v[i].exp) begin
        n_fail++;
        $display("FAIL perf_seq[%0d]: got %h expected %h", i, obs, v[i].exp);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (cycle_count !== 32'd14) begin
      n_fail++;
      $display("FAIL perf_cycles: got %0d expected 14", cycle_count);
    end
    n_tests++;
    if (instret_count !== 32'd3) begin
      n_fail++;
      $display("FAIL perf_instret: got %0d expected 3", instret_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_arith();
    test_load_store();
    test_branch_jump();
    test_ecall_halt();
    test_timeout();
`ifdef PERF_COUNTER_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control_fsm.md
Name: multi_cycle_control_fsm

Overview:
- Sequencing controller for the multi-cycle RISC-V core. It replaces the single-cycle decode-everything-at-once control.
- Steps each instruction through IF/ID/EX/MEM/WB.
- Drives the datapath muxes, register-file and memory enables, and the PC write.
- Selects whether the ALU takes its opcode from alu_control_unit or a forced ADD.
- Handshakes with a variable-latency unified memory (req/ready) and halts on ECALL.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles a memory request may wait for mem_ready before the FSM enters ERR.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- opcode  in  7  IR[6:0], valid from ID onward
- branch_taken  in  1  ALU compare result, valid in EX for BRANCH
- ecall_halt  in  1  x17==10 condition, sampled in ID
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a write (0 = read)
- i_or_d  out  1  address mux: 0=PC, 1=ALUOut
- ir_write  out  1  load IR from memory data
- mdr_write  out  1  load MDR from memory data
- reg_write  out  1  register-file write enable
- wb_sel  out  2  0=ALUOut, 1=MDR, 2=PC+4
- alu_src_a  out  1  0=PC, 1=rs1
- alu_src_b  out  2  0=rs2, 1=imm, 2=constant 4
- alu_force_add  out  1  1 = ALU opcode ADD; 0 = use alu_control_unit
- pc_write  out  1  unconditional PC update
- pc_source  out  2  0=ALU result, 1=ALUOut, 2=ALU result & ~1 (JALR)
- is_halted  out  1  sticky halt
- bus_error  out  1  sticky timeout error
- state  out  3  current state, for debug

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, ERR=6. Code 7 is illegal and goes to ERR next cycle.
- Reset (reset_n=0 at a clk edge):
  - State = IF; timeout counter = 0.
  - is_halted = 0, bus_error = 0.
  - Reset wins over every other event, including mid-memory-wait.
- All outputs are combinational from the registered state plus inputs (Moore/Mealy as noted). Unlisted outputs are 0 in each state.
- IF:
  - mem_req=1, i_or_d=0.
  - Concurrently: alu_src_a=0, alu_src_b=2, alu_force_add=1, pc_source=0.
  - On mem_ready (Mealy): ir_write=1, pc_write=1 (PC←PC+4), then go to ID.
  - Otherwise stay in IF.
- ID:
  - alu_src_a=0, alu_src_b=1, alu_force_add=1; ALUOut←PC_old+imm for the branch target. The datapath keeps PC_old.
  - If opcode==ECALL and ecall_halt=1, go to HALT; ECALL without halt goes to IF.
  - Unknown opcode goes to IF as a NOP.
  - Otherwise go to EX.
- EX, by opcode:
  - ARITHMETIC: src_a=1, src_b=0, force_add=0 → WB.
  - ARITHMETIC_IMM: src_a=1, src_b=1, force_add=0 → WB.
  - LOAD/STORE: src_a=1, src_b=1, force_add=1 → MEM.
  - BRANCH: src_a=1, src_b=0, force_add=0. If branch_taken then pc_write=1, pc_source=1. Next state is IF.
  - JAL: pc_write=1, pc_source=1, reg_write=1, wb_sel=2 → IF.
  - JALR: src_a=1, src_b=1, force_add=1, pc_write=1, pc_source=2, reg_write=1, wb_sel=2 → IF.
  - PC+4 for wb_sel=2 is PC_old+4, supplied by the datapath.
- MEM:
  - mem_req=1, i_or_d=1, mem_write=(opcode==STORE).
  - On mem_ready: LOAD asserts mdr_write=1 and goes to WB; STORE goes to IF.
- WB:
  - reg_write=1.
  - wb_sel = 1 if opcode==LOAD, else 0.
  - Next state is IF.
- Timeout counter:
  - Increments each cycle in IF or MEM while mem_ready=0; clears on mem_ready or on state change.
  - When it reaches TIMEOUT_CYCLES with mem_ready still 0, go to ERR.
  - mem_ready in the same cycle the counter hits the limit counts as success.
- HALT / ERR:
  - Absorbing until reset. All enables are 0.
  - is_halted=1 in HALT; bus_error=1 and is_halted=1 in ERR.
- mem_ready outside IF/MEM is ignored. mem_req never asserts in HALT or ERR.

Optional Feature:
- Macro: PERF_COUNTER_EN.
- Defined: adds outputs cycle_count[31:0] and instret_count[31:0].
  - cycle_count increments every cycle while not HALT/ERR.
  - instret_count increments on each transition into IF from ID, EX, MEM or WB.
  - Both clear on reset and wrap modulo 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- ADD x3,x1,x2 with mem_ready=1 on the first IF cycle → states IF,ID,EX,WB,IF (4 cycles). alu_force_add=0 in EX; reg_write=1 and wb_sel=0 in WB.
- LW with mem_ready delayed 3 cycles in both IF and MEM → 4 IF cycles, ir_write pulses once. mdr_write pulses once in the last MEM cycle. WB has wb_sel=1; total 11 cycles.
- BEQ taken, then BEQ not taken → pc_write=1, pc_source=1 in EX for taken only. Both return to IF after 3 cycles.
- ECALL with ecall_halt=1 → HALT after ID; is_halted=1. mem_req stays 0 for 20 further cycles.
- TIMEOUT_CYCLES=4, mem_ready held 0 in IF → ERR entered on the 5th cycle; bus_error=1. A reset_n=0 pulse returns to IF with bus_error=0.
- PERF_COUNTER_EN defined, 3 ADDs then halting ECALL → instret_count=3. cycle_count equals the total cycles before HALT, then freezes.
